// File: rtl/mt_stream_rr_mux.sv
// Packet-atomic round-robin N:1 stream multiplexer with one registered output stage.
// Optional mid-packet starvation abort is compiled in with `define MT_STREAM_MUX_TIMEOUT_EN.
module mt_stream_rr_mux #(
  parameter int  G_NUM_CHANNELS   = 4,
  parameter int  G_DATA_WIDTH     = 32,
  parameter int  G_TIMEOUT_CYCLES = 1024,
  localparam int C_CHAN_W         = (G_NUM_CHANNELS > 1) ? $clog2(G_NUM_CHANNELS) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [G_NUM_CHANNELS-1:0]              snk_valid_i,
  input  logic [G_NUM_CHANNELS-1:0]              snk_last_i,
  input  logic [G_NUM_CHANNELS*G_DATA_WIDTH-1:0] snk_data_i,
  output logic [G_NUM_CHANNELS-1:0]              snk_ready_o,
  output logic                                   src_valid_o,
  output logic                                   src_last_o,
  output logic [G_DATA_WIDTH-1:0]                src_data_o,
  output logic [C_CHAN_W-1:0]                    src_chan_o,
  input  logic                                   src_ready_i,
  output logic                                   err_timeout_o
);

`ifdef MT_STREAM_MUX_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_BUSY} state_t;
`endif

  state_t                    r_state, w_state_nxt;
  logic [C_CHAN_W-1:0]       r_ptr, w_ptr_nxt;
  logic [C_CHAN_W-1:0]       r_grant, w_grant_nxt;
  logic                      r_src_valid, r_src_last;
  logic [G_DATA_WIDTH-1:0]   r_src_data;
  logic [C_CHAN_W-1:0]       r_src_chan;

  logic                      w_out_free;
  logic                      w_g_valid, w_g_last, w_acc;
  logic [G_DATA_WIDTH-1:0]   w_g_data;
  logic                      w_arb_any;
  logic [C_CHAN_W-1:0]       w_arb_chan;
  logic                      w_to_hit, w_to_load;

  function automatic logic [C_CHAN_W-1:0] next_chan(input logic [C_CHAN_W-1:0] c);
    if (int'(c) >= G_NUM_CHANNELS - 1) return '0;
    return c + C_CHAN_W'(1);
  endfunction

  assign w_out_free = ~r_src_valid | src_ready_i;
  assign w_g_valid  = snk_valid_i[r_grant];
  assign w_g_last   = snk_last_i[r_grant];
  assign w_g_data   = snk_data_i[int'(r_grant)*G_DATA_WIDTH +: G_DATA_WIDTH];
  assign w_acc      = w_g_valid & snk_ready_o[r_grant];
  assign w_arb_any  = |snk_valid_i;

  // Scan from the highest offset down so the channel closest to r_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_arb_chan = r_ptr;
    for (int i = G_NUM_CHANNELS - 1; i >= 0; i--) begin
      logic [C_CHAN_W-1:0] v_idx;
      v_idx = C_CHAN_W'((int'(r_ptr) + i) % G_NUM_CHANNELS);
      if (snk_valid_i[v_idx]) w_arb_chan = v_idx;
    end
  end

`ifdef MT_STREAM_MUX_TIMEOUT_EN
  localparam int C_CNT_W = $clog2(G_TIMEOUT_CYCLES + 1);
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_err;

  assign w_to_hit      = (r_state == S_BUSY) && (r_cnt == C_CNT_W'(G_TIMEOUT_CYCLES));
  assign err_timeout_o = r_err;

  // Counts idle cycles of the granted channel; holds at the limit until the abort beat loads.
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != S_BUSY || w_acc) r_cnt <= '0;
    else if (!w_g_valid && !w_to_hit)        r_cnt <= r_cnt + C_CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_err <= 1'b0;
    else       r_err <= w_to_load;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (G_TIMEOUT_CYCLES > 0);
  assign w_to_hit         = 1'b0;
  assign err_timeout_o    = 1'b0;
`endif

  always_comb begin
    snk_ready_o = '0;
    if (r_state == S_BUSY && w_out_free && !w_to_hit) snk_ready_o[r_grant] = 1'b1;
`ifdef MT_STREAM_MUX_TIMEOUT_EN
    if (r_state == S_DRAIN) snk_ready_o[r_grant] = 1'b1;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_to_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_any) begin
          w_grant_nxt = w_arb_chan;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_acc && w_g_last) begin
          w_ptr_nxt   = next_chan(r_grant);
          w_state_nxt = S_IDLE;
        end else if (w_to_hit && w_out_free) begin
          w_to_load   = 1'b1;
`ifdef MT_STREAM_MUX_TIMEOUT_EN
          w_state_nxt = S_DRAIN;
`endif
        end
      end
`ifdef MT_STREAM_MUX_TIMEOUT_EN
      S_DRAIN: begin
        if (w_acc && w_g_last) begin
          w_ptr_nxt   = next_chan(r_grant);
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // Output stage: data is held while stalled; only valid drops when it drains with nothing new.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_src_valid <= 1'b0;
      r_src_last  <= 1'b0;
      r_src_data  <= '0;
      r_src_chan  <= '0;
    end else if (w_out_free) begin
      if (r_state == S_BUSY && w_acc) begin
        r_src_valid <= 1'b1;
        r_src_last  <= w_g_last;
        r_src_data  <= w_g_data;
        r_src_chan  <= r_grant;
      end else if (w_to_load) begin
        r_src_valid <= 1'b1;
        r_src_last  <= 1'b1;
        r_src_data  <= '0;
        r_src_chan  <= r_grant;
      end else begin
        r_src_valid <= 1'b0;
      end
    end
  end

  assign src_valid_o = r_src_valid;
  assign src_last_o  = r_src_last;
  assign src_data_o  = r_src_data;
  assign src_chan_o  = r_src_chan;

endmodule

// File: tb/tb_mt_stream_rr_mux.sv
// Directed bench for mt_stream_rr_mux (N=4, W=32, timeout limit 8); follows MT_STREAM_MUX_TIMEOUT_EN.
module tb_mt_stream_rr_mux;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          gap;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  chan;
  } obeat_t;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N-1:0]   snk_valid_i, snk_last_i, snk_ready_o;
  logic [N*W-1:0] snk_data_i;
  logic           src_valid_o, src_last_o, src_ready_i, err_timeout_o;
  logic [W-1:0]   src_data_o;
  logic [1:0]     src_chan_o;

  mt_stream_rr_mux #(
    .G_NUM_CHANNELS  (N),
    .G_DATA_WIDTH    (W),
    .G_TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .snk_valid_i  (snk_valid_i),
    .snk_last_i   (snk_last_i),
    .snk_data_i   (snk_data_i),
    .snk_ready_o  (snk_ready_o),
    .src_valid_o  (src_valid_o),
    .src_last_o   (src_last_o),
    .src_data_o   (src_data_o),
    .src_chan_o   (src_chan_o),
    .src_ready_i  (src_ready_i),
    .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  beat_t  src_q[N][$];
  beat_t  exp_q[N][$];
  obeat_t out_q[$];
  logic [N-1:0] acc = '0;
  bit     rdy_random = 1'b0;
  int     cyc = 0, first_valid_cyc = -1, first_out_cyc = -1, err_cnt = 0;
  int     n_checks = 0, n_fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input int c, input logic [31:0] d, input logic l, input int g);
    beat_t b;
    b.data = d; b.last = l; b.gap = g;
    src_q[c].push_back(b);
  endtask

  // Inputs change on the falling edge; acceptance and output beats are sampled 1 time unit later.
  initial begin
    snk_valid_i = '0; snk_last_i = '0; snk_data_i = '0; src_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < N; c++)
        if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      acc = '0;
      src_ready_i = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 0; c < N; c++) begin
        snk_valid_i[c] = 1'b0;
        snk_last_i[c]  = 1'b0;
        if (src_q[c].size() > 0) begin
          beat_t b;
          b = src_q[c][0];
          if (b.gap > 0) begin
            b.gap--;
            src_q[c][0] = b;
          end else begin
            snk_valid_i[c]          = 1'b1;
            snk_last_i[c]           = b.last;
            snk_data_i[c*W +: W]    = b.data;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
          end
        end
      end
      #1;
      acc = snk_valid_i & snk_ready_o;
      if (src_valid_o && src_ready_i) begin
        obeat_t o;
        o.data = src_data_o; o.last = src_last_o; o.chan = src_chan_o;
        out_q.push_back(o);
        if (first_out_cyc < 0) first_out_cyc = cyc;
      end
      if (err_timeout_o) err_cnt++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    for (int c = 0; c < N; c++) src_q[c].delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
    acc = '0;
    out_q.delete();
    first_valid_cyc = -1;
    first_out_cyc   = -1;
    err_cnt         = 0;
  endtask

  // Waits a bounded time for n beats, then lets extra beats surface before counting.
  task automatic wait_out(input int n, input int budget, input string tag);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_beat_count"}, out_q.size(), n);
  endtask

  task automatic check_beat(input string tag, input int i, input logic [31:0] d,
                            input logic l, input logic [1:0] ch);
    if (i < out_q.size()) begin
      check({tag, "_data"}, out_q[i].data, d);
      check({tag, "_last"}, 32'(out_q[i].last), 32'(l));
      check({tag, "_chan"}, 32'(out_q[i].chan), 32'(ch));
    end
  endtask

  initial begin
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_src_valid", 32'(src_valid_o), 0);
    check("rst_src_last",  32'(src_last_o), 0);
    check("rst_src_data",  src_data_o, 0);
    check("rst_src_chan",  32'(src_chan_o), 0);
    check("rst_snk_ready", 32'(snk_ready_o), 0);
    check("rst_err",       32'(err_timeout_o), 0);
    rst_i = 1'b0;

    // 1: lone channel 2, 16-beat packet, two-cycle first-beat latency
    do_reset();
    for (int i = 0; i < 16; i++) push_beat(2, 32'(i), i == 15, 0);
    wait_out(16, 100, "t1");
    for (int i = 0; i < 16; i++) check_beat("t1", i, 32'(i), i == 15, 2'd2);
    check("t1_latency", 32'(first_out_cyc - first_valid_cyc), 2);

    // 2: all channels queue three 4-beat packets; grants rotate 0..3
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < N; c++)
        for (int b = 0; b < 4; b++) push_beat(c, 32'(c*256 + p*16 + b), b == 3, 0);
    wait_out(48, 400, "t2");
    for (int k = 0; k < 12; k++)
      for (int b = 0; b < 4; b++)
        check_beat("t2", k*4 + b, 32'((k%4)*256 + (k/4)*16 + b), b == 3, 2'(k%4));

    // 3: random source gaps and downstream stalls; per-channel packets must arrive intact
    do_reset();
    begin
      int total = 0;
      for (int c = 0; c < N; c++) exp_q[c].delete();
      for (int c = 0; c < N; c++)
        for (int p = 0; p < 3; p++) begin
          int len = 1 + (p + c) % 4;
          for (int b = 0; b < len; b++) begin
            beat_t e;
            e.data = 32'h1000 + 32'(c*256 + p*16 + b);
            e.last = (b == len - 1);
            e.gap  = int'($urandom_range(0, 1));
            exp_q[c].push_back(e);
            src_q[c].push_back(e);
            total++;
          end
        end
      rdy_random = 1'b1;
      wait_out(total, 3000, "t3");
      rdy_random = 1'b0;
      begin
        bit in_pkt = 1'b0;
        logic [1:0] cur = '0;
        foreach (out_q[i]) begin
          if (in_pkt) check("t3_no_interleave", 32'(out_q[i].chan), 32'(cur));
          cur = out_q[i].chan;
          if (exp_q[cur].size() == 0) begin
            check("t3_unexpected_beat", 32'(exp_q[cur].size()), 1);
          end else begin
            beat_t e;
            e = exp_q[cur].pop_front();
            check("t3_data", out_q[i].data, e.data);
            check("t3_last", 32'(out_q[i].last), 32'(e.last));
          end
          in_pkt = !out_q[i].last;
        end
        for (int c = 0; c < N; c++) check("t3_left_over", 32'(exp_q[c].size()), 0);
      end
    end

    // 4: reset in the middle of a ch1 packet, then a ch3 packet
    do_reset();
    for (int i = 0; i < 10; i++) push_beat(1, 32'h100 + 32'(i), i == 9, 0);
    begin
      int k = 0;
      while (out_q.size() < 5 && k < 100) begin
        @(posedge clk);
        k++;
      end
      check("t4_reached_5_beats", 32'(out_q.size() >= 5), 1);
    end
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("t4_valid_after_rst", 32'(src_valid_o), 0);
    check("t4_ready_after_rst", 32'(snk_ready_o), 0);
    src_q[1].delete();
    acc = '0;
    out_q.delete();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) push_beat(3, 32'h300 + 32'(i), i == 2, 0);
    wait_out(3, 50, "t4");
    for (int i = 0; i < 3; i++) check_beat("t4", i, 32'h300 + 32'(i), i == 2, 2'd3);

    // 5/6: ch0 stalls 20 cycles mid-packet while ch1 waits
    do_reset();
    push_beat(0, 32'h50, 1'b0, 0);
    push_beat(0, 32'h51, 1'b0, 0);
    push_beat(0, 32'h52, 1'b0, 0);
    push_beat(0, 32'h53, 1'b0, 20);
    push_beat(0, 32'h54, 1'b1, 0);
    push_beat(1, 32'h60, 1'b0, 0);
    push_beat(1, 32'h61, 1'b1, 0);
`ifdef MT_STREAM_MUX_TIMEOUT_EN
    wait_out(6, 200, "t5");
    check_beat("t5", 0, 32'h50, 1'b0, 2'd0);
    check_beat("t5", 1, 32'h51, 1'b0, 2'd0);
    check_beat("t5", 2, 32'h52, 1'b0, 2'd0);
    check_beat("t5", 3, 32'h00, 1'b1, 2'd0);
    check_beat("t5", 4, 32'h60, 1'b0, 2'd1);
    check_beat("t5", 5, 32'h61, 1'b1, 2'd1);
    check("t5_err_pulses", 32'(err_cnt), 1);
`else
    wait_out(7, 200, "t6");
    for (int i = 0; i < 5; i++) check_beat("t6", i, 32'h50 + 32'(i), i == 4, 2'd0);
    check_beat("t6", 5, 32'h60, 1'b0, 2'd1);
    check_beat("t6", 6, 32'h61, 1'b1, 2'd1);
    check("t6_err_pulses", 32'(err_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
